// File: rtl/line_beat_buffer_pkg.sv
// Shared definitions for the line/beat buffer: FSM state encoding and default geometry.
package line_beat_buffer_pkg;

  localparam int DEFAULT_LINE_WIDTH = 64;
  localparam int DEFAULT_BEAT_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_DRAIN = 2'd2
  } buf_state_t;

  function automatic int beats_per_line(input int line_width, input int beat_width);
    return line_width / beat_width;
  endfunction

endpackage

// File: rtl/line_beat_buffer_if.sv
// Command, fill-beat, writeback-beat and status signals of the line/beat buffer.
interface line_beat_buffer_if import line_beat_buffer_pkg::*; #(
  parameter int LINE_WIDTH = DEFAULT_LINE_WIDTH,
  parameter int BEAT_WIDTH = DEFAULT_BEAT_WIDTH
);

  localparam int BEATS = beats_per_line(LINE_WIDTH, BEAT_WIDTH);
  localparam int CW    = $clog2(BEATS);

  logic                  fill_start;
  logic [CW-1:0]         fill_offset;
  logic                  in_valid;
  logic [BEAT_WIDTH-1:0] in_data;
  logic                  in_ready;
  logic                  fill_done;
  logic                  wb_load;
  logic [LINE_WIDTH-1:0] wb_line;
  logic                  out_valid;
  logic [BEAT_WIDTH-1:0] out_data;
  logic                  out_last;
  logic                  out_ready;
  logic                  abort;
  logic                  busy;
  logic [LINE_WIDTH-1:0] line_dout;

  // The master side is the cache controller / memory bus, the slave side is the buffer.
  modport master (
    output fill_start, fill_offset, in_valid, in_data, wb_load, wb_line, out_ready, abort,
    input  in_ready, fill_done, out_valid, out_data, out_last, busy, line_dout
  );

  modport slave (
    input  fill_start, fill_offset, in_valid, in_data, wb_load, wb_line, out_ready, abort,
    output in_ready, fill_done, out_valid, out_data, out_last, busy, line_dout
  );

endinterface

// File: rtl/line_beat_buffer_beat_counter.sv
// CW-bit modulo counter with clear > load > increment priority.
module beat_counter import line_beat_buffer_pkg::*; #(
  parameter int CW = 2
) (
  input  logic          clk,
  input  logic          not_reset,
  input  logic          clear,
  input  logic          load,
  input  logic [CW-1:0] load_value,
  input  logic          inc,
  output logic [CW-1:0] count
);

  always_ff @(posedge clk or negedge not_reset) begin
    if (!not_reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/line_beat_buffer.sv
// Bidirectional cache-line buffer: beat-wise fill into, and beat-wise drain out of, one line register.
// Define LINE_BUF_CWF_EN to start fills at fill_offset (critical-word-first); otherwise fills start at 0.
module line_beat_buffer import line_beat_buffer_pkg::*; #(
  parameter int LINE_WIDTH = DEFAULT_LINE_WIDTH,
  parameter int BEAT_WIDTH = DEFAULT_BEAT_WIDTH
) (
  input logic               clk,
  input logic               not_reset,
  line_beat_buffer_if.slave bus
);

  localparam int            BEATS    = beats_per_line(LINE_WIDTH, BEAT_WIDTH);
  localparam int            CW       = $clog2(BEATS);
  localparam logic [CW-1:0] LAST_IDX = CW'(BEATS - 1);

  buf_state_t            state;
  buf_state_t            state_next;
  logic [LINE_WIDTH-1:0] line;
  logic [CW-1:0]         idx;
  logic [CW-1:0]         beat_cnt;
  logic [CW-1:0]         start_idx;
  logic [CW-1:0]         idx_load_value;
  logic                  idx_clear;
  logic                  idx_load;
  logic                  idx_inc;
  logic                  cnt_clear;
  logic                  fill_accept;
  logic                  drain_accept;
  logic                  fill_last;
  logic                  capture_line;
  logic                  fill_done_q;

`ifdef LINE_BUF_CWF_EN
  assign start_idx = bus.fill_offset;
`else
  logic unused_fill_offset;
  assign unused_fill_offset = ^bus.fill_offset;
  assign start_idx          = '0;
`endif

  beat_counter #(.CW(CW)) u_idx (
    .clk        (clk),
    .not_reset  (not_reset),
    .clear      (idx_clear),
    .load       (idx_load),
    .load_value (idx_load_value),
    .inc        (idx_inc),
    .count      (idx)
  );

  beat_counter #(.CW(CW)) u_beat_cnt (
    .clk        (clk),
    .not_reset  (not_reset),
    .clear      (cnt_clear),
    .load       (1'b0),
    .load_value ('0),
    .inc        (fill_accept),
    .count      (beat_cnt)
  );

  always_ff @(posedge clk or negedge not_reset) begin
    if (!not_reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // abort overrides everything, including a beat offered in the same cycle.
  always_comb begin
    state_next     = state;
    fill_accept    = 1'b0;
    drain_accept   = 1'b0;
    fill_last      = 1'b0;
    capture_line   = 1'b0;
    idx_clear      = bus.abort;
    idx_load       = 1'b0;
    idx_load_value = '0;
    cnt_clear      = bus.abort;
    if (bus.abort) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.fill_start) begin
            state_next     = ST_FILL;
            idx_load       = 1'b1;
            idx_load_value = start_idx;
            cnt_clear      = 1'b1;
          end else if (bus.wb_load) begin
            state_next   = ST_DRAIN;
            idx_load     = 1'b1;
            capture_line = 1'b1;
          end
        end
        ST_FILL: begin
          if (bus.in_valid) begin
            fill_accept = 1'b1;
            if (beat_cnt == LAST_IDX) begin
              fill_last  = 1'b1;
              state_next = ST_IDLE;
            end
          end
        end
        ST_DRAIN: begin
          if (bus.out_ready) begin
            drain_accept = 1'b1;
            if (idx == LAST_IDX) begin
              state_next = ST_IDLE;
            end
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  assign idx_inc = fill_accept | drain_accept;

  always_ff @(posedge clk or negedge not_reset) begin
    if (!not_reset) begin
      line <= '0;
    end else if (capture_line) begin
      line <= bus.wb_line;
    end else if (fill_accept) begin
      line[idx*BEAT_WIDTH +: BEAT_WIDTH] <= bus.in_data;
    end
  end

  always_ff @(posedge clk or negedge not_reset) begin
    if (!not_reset) begin
      fill_done_q <= 1'b0;
    end else begin
      fill_done_q <= fill_last;
    end
  end

  assign bus.in_ready  = (state == ST_FILL) && !bus.abort;
  assign bus.out_valid = (state == ST_DRAIN);
  assign bus.out_data  = line[idx*BEAT_WIDTH +: BEAT_WIDTH];
  assign bus.out_last  = (state == ST_DRAIN) && (idx == LAST_IDX);
  assign bus.fill_done = fill_done_q;
  assign bus.busy      = (state != ST_IDLE);
  assign bus.line_dout = line;

endmodule

// File: tb/tb_line_beat_buffer.sv
// Randomized self-checking bench for line_beat_buffer against a line-level reference model.
module tb_line_beat_buffer;

  logic clk;
  logic not_reset;
  int   check_count;
  int   error_count;
  logic [63:0] model_line;

  line_beat_buffer_if #(.LINE_WIDTH(64), .BEAT_WIDTH(16)) bus ();

  line_beat_buffer #(.LINE_WIDTH(64), .BEAT_WIDTH(16)) dut (
    .clk       (clk),
    .not_reset (not_reset),
    .bus       (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    check_count++;
    if (actual !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  task automatic idle_inputs();
    bus.fill_start  = 1'b0;
    bus.fill_offset = 2'd0;
    bus.in_valid    = 1'b0;
    bus.in_data     = 16'd0;
    bus.wb_load     = 1'b0;
    bus.wb_line     = 64'd0;
    bus.out_ready   = 1'b0;
    bus.abort       = 1'b0;
  endtask

  // Beat k of a fill lands in slot (start + k) mod 4.
  task automatic do_fill(input logic [63:0] beats, input logic [1:0] offset, input bit gaps, input bit junk);
    int start;
    int k;
    int slot;
`ifdef LINE_BUF_CWF_EN
    start = int'(offset);
`else
    start = 0;
`endif
    @(negedge clk);
    bus.fill_start  = 1'b1;
    bus.fill_offset = offset;
    bus.wb_load     = junk;
    bus.wb_line     = {$urandom, $urandom};
    @(negedge clk);
    bus.fill_start = 1'b0;
    bus.wb_load    = 1'b0;
    #1;
    checkOutput("fill_busy", 64'(bus.busy), 64'd1);
    k = 0;
    while (k < 4) begin
      bus.in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.in_data  = bus.in_valid ? beats[k*16 +: 16] : 16'($urandom);
      if (junk) begin
        bus.fill_start = 1'($urandom_range(0, 1));
        bus.wb_load    = 1'($urandom_range(0, 1));
        bus.wb_line    = {$urandom, $urandom};
      end
      #1;
      checkOutput("fill_in_ready", 64'(bus.in_ready), 64'd1);
      checkOutput("fill_done_early", 64'(bus.fill_done), 64'd0);
      if (bus.in_valid) begin
        slot = (start + k) % 4;
        model_line[slot*16 +: 16] = beats[k*16 +: 16];
        k++;
      end
      @(negedge clk);
    end
    bus.in_valid   = 1'b0;
    bus.fill_start = 1'b0;
    bus.wb_load    = 1'b0;
    #1;
    checkOutput("fill_done", 64'(bus.fill_done), 64'd1);
    checkOutput("fill_idle", 64'(bus.busy), 64'd0);
    checkOutput("fill_ready_off", 64'(bus.in_ready), 64'd0);
    checkOutput("fill_line", bus.line_dout, model_line);
    @(negedge clk);
    #1;
    checkOutput("fill_done_pulse", 64'(bus.fill_done), 64'd0);
  endtask

  // stall_mode: 0 always ready, 1 random ready, 2 repeating ready pattern 1,0,0,1.
  task automatic do_drain(input logic [63:0] line_val, input int stall_mode, input bit junk);
    int k;
    int cyc;
    @(negedge clk);
    bus.wb_load = 1'b1;
    bus.wb_line = line_val;
    @(negedge clk);
    bus.wb_load = 1'b0;
    bus.wb_line = {$urandom, $urandom};
    model_line  = line_val;
    k   = 0;
    cyc = 0;
    while (k < 4) begin
      case (stall_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = 1'($urandom_range(0, 1));
        default: bus.out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      endcase
      if (cyc >= 40) bus.out_ready = 1'b1;
      if (junk) begin
        bus.fill_start = 1'($urandom_range(0, 1));
        bus.wb_load    = 1'($urandom_range(0, 1));
      end
      #1;
      checkOutput("drain_valid", 64'(bus.out_valid), 64'd1);
      checkOutput("drain_data", 64'(bus.out_data), 64'(model_line[k*16 +: 16]));
      checkOutput("drain_last", 64'(bus.out_last), 64'(k == 3));
      checkOutput("drain_line_held", bus.line_dout, model_line);
      if (bus.out_ready) k++;
      cyc++;
      @(negedge clk);
    end
    bus.out_ready  = 1'($urandom_range(0, 1));
    bus.fill_start = 1'b0;
    bus.wb_load    = 1'b0;
    #1;
    checkOutput("drain_end_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("drain_end_last", 64'(bus.out_last), 64'd0);
    checkOutput("drain_end_busy", 64'(bus.busy), 64'd0);
    checkOutput("drain_end_line", bus.line_dout, model_line);
    bus.out_ready = 1'b0;
  endtask

  task automatic do_abort_tests();
    logic [1:0] offset;
    int start;
    offset = 2'($urandom_range(0, 3));
`ifdef LINE_BUF_CWF_EN
    start = int'(offset);
`else
    start = 0;
`endif
    // Same-cycle fill_start and wb_load: fill must win and the writeback line is dropped.
    @(negedge clk);
    bus.fill_start  = 1'b1;
    bus.wb_load     = 1'b1;
    bus.wb_line     = 64'hFFFF_EEEE_DDDD_CCCC;
    bus.fill_offset = offset;
    @(negedge clk);
    bus.fill_start = 1'b0;
    bus.wb_load    = 1'b0;
    #1;
    checkOutput("prio_fill_ready", 64'(bus.in_ready), 64'd1);
    checkOutput("prio_no_drain", 64'(bus.out_valid), 64'd0);
    for (int b = 0; b < 2; b++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = 16'($urandom);
      model_line[((start + b) % 4)*16 +: 16] = bus.in_data;
    end
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = 16'hBAD0;
    bus.abort    = 1'b1;
    #1;
    checkOutput("abort_blocks_ready", 64'(bus.in_ready), 64'd0);
    @(negedge clk);
    bus.abort    = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    checkOutput("abort_fill_busy", 64'(bus.busy), 64'd0);
    checkOutput("abort_fill_done", 64'(bus.fill_done), 64'd0);
    checkOutput("abort_fill_line", bus.line_dout, model_line);
    @(negedge clk);
    #1;
    checkOutput("abort_fill_done_late", 64'(bus.fill_done), 64'd0);

    // abort also beats a command issued in IDLE.
    bus.fill_start = 1'b1;
    bus.abort      = 1'b1;
    @(negedge clk);
    bus.fill_start = 1'b0;
    bus.abort      = 1'b0;
    #1;
    checkOutput("abort_beats_cmd", 64'(bus.busy), 64'd0);

    // Abort mid-drain leaves the captured line in place.
    bus.wb_load = 1'b1;
    bus.wb_line = {$urandom, $urandom};
    model_line  = bus.wb_line;
    @(negedge clk);
    bus.wb_load   = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort     = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    checkOutput("abort_drain_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("abort_drain_line", bus.line_dout, model_line);
  endtask

  task automatic do_reset_test();
    @(negedge clk);
    bus.wb_load = 1'b1;
    bus.wb_line = {$urandom, $urandom};
    @(negedge clk);
    bus.wb_load   = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    not_reset = 1'b0;
    #1;
    model_line = 64'd0;
    checkOutput("rst_mid_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("rst_mid_last", 64'(bus.out_last), 64'd0);
    checkOutput("rst_mid_busy", 64'(bus.busy), 64'd0);
    checkOutput("rst_mid_line", bus.line_dout, 64'd0);
    @(negedge clk);
    not_reset     = 1'b1;
    bus.out_ready = 1'b0;
    do_drain({$urandom, $urandom}, 1, 1'b0);
  endtask

  // Directed cases from the datasheet followed by a randomized mix of fills and drains.
  task automatic applyStimulus();
    do_fill(64'h4444_3333_2222_1111, 2'd0, 1'b0, 1'b0);
    checkOutput("fill_directed", bus.line_dout, 64'h4444_3333_2222_1111);
    do_drain(64'hDEAD_BEEF_0123_4567, 0, 1'b0);
    do_drain(64'h0F0F_A5A5_5A5A_F0F0, 2, 1'b0);
    do_fill(64'hDDDD_CCCC_BBBB_AAAA, 2'd2, 1'b0, 1'b0);
`ifdef LINE_BUF_CWF_EN
    checkOutput("fill_cwf_directed", bus.line_dout, 64'hBBBB_AAAA_DDDD_CCCC);
`endif
    do_abort_tests();
    do_drain(model_line, 0, 1'b0);
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        do_fill({$urandom, $urandom}, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)));
      end else begin
        do_drain({$urandom, $urandom}, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
      end
    end
    do_reset_test();
  endtask

  initial begin
    check_count = 0;
    error_count = 0;
    model_line  = 64'd0;
    not_reset   = 1'b0;
    idle_inputs();
    @(negedge clk);
    #1;
    checkOutput("rst_in_ready", 64'(bus.in_ready), 64'd0);
    checkOutput("rst_out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("rst_out_last", 64'(bus.out_last), 64'd0);
    checkOutput("rst_fill_done", 64'(bus.fill_done), 64'd0);
    checkOutput("rst_busy", 64'(bus.busy), 64'd0);
    checkOutput("rst_line", bus.line_dout, 64'd0);
    @(negedge clk);
    not_reset = 1'b1;
    applyStimulus();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
